// File: rtl/simmem_resp_bank_if.sv
// Request, memory-response and released-response channels of simmem_resp_bank.
// Signal suffixes are named from the bank's side (slave modport).
interface simmem_resp_bank_if #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 8,
  parameter int unsigned CounterWidth = 8,
  parameter int unsigned NumEntries   = 16
);
  localparam int unsigned OccWidth = $clog2(NumEntries + 1);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [IdWidth-1:0]      req_id_i;

  logic                    resp_in_valid_i;
  logic                    resp_in_ready_o;
  logic [IdWidth-1:0]      resp_in_id_i;
  logic [DataWidth-1:0]    resp_in_data_i;
  logic [CounterWidth-1:0] resp_in_delay_i;

  logic                    resp_out_valid_o;
  logic                    resp_out_ready_i;
  logic [IdWidth-1:0]      resp_out_id_o;
  logic [DataWidth-1:0]    resp_out_data_o;

  logic [OccWidth-1:0]     occupancy_o;

  modport slave (
    input  req_valid_i, req_id_i,
    output req_ready_o,
    input  resp_in_valid_i, resp_in_id_i, resp_in_data_i, resp_in_delay_i,
    output resp_in_ready_o,
    output resp_out_valid_o, resp_out_id_o, resp_out_data_o,
    input  resp_out_ready_i,
    output occupancy_o
  );

  modport master (
    output req_valid_i, req_id_i,
    input  req_ready_o,
    output resp_in_valid_i, resp_in_id_i, resp_in_data_i, resp_in_delay_i,
    input  resp_in_ready_o,
    input  resp_out_valid_o, resp_out_id_o, resp_out_data_o,
    output resp_out_ready_i,
    input  occupancy_o
  );
endinterface

// File: rtl/simmem_resp_bank.sv
// Multi-entry simulated-memory response delay bank with oldest-first release.
// Define SIMMEM_ID_ORDER_EN to hold a DONE entry behind any older live entry of the same ID.
module simmem_resp_bank #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 8,
  parameter int unsigned CounterWidth = 8,
  parameter int unsigned NumEntries   = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  simmem_resp_bank_if.slave bus_io
);
  localparam int unsigned IdxWidth = $clog2(NumEntries);
  localparam int unsigned OccWidth = $clog2(NumEntries + 1);

  typedef enum logic [1:0] {StFree, StWait, StDelay, StDone} entry_state_e;

  entry_state_e            state_q [NumEntries];
  entry_state_e            state_d [NumEntries];
  logic [IdWidth-1:0]      id_q    [NumEntries];
  logic [IdWidth-1:0]      id_d    [NumEntries];
  logic [CounterWidth-1:0] cnt_q   [NumEntries];
  logic [CounterWidth-1:0] cnt_d   [NumEntries];
  logic [DataWidth-1:0]    data_q  [NumEntries];
  // older_q[i][j] set means entry j was allocated before entry i
  logic [NumEntries-1:0]   older_q [NumEntries];
  logic [NumEntries-1:0]   older_d [NumEntries];

  logic                 out_valid_q, out_valid_d;
  logic [IdWidth-1:0]   out_id_q, out_id_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [OccWidth-1:0]  occ_q, occ_d;

  logic [NumEntries-1:0] free_vec, busy_vec, match_vec, done_vec, elig_vec;
  logic [NumEntries-1:0] match_sel, rel_sel;
  logic [IdxWidth-1:0]   alloc_idx, match_idx, rel_idx;
  logic                  alloc_en, match_en, load_en, release_en;

  always_comb begin
    free_vec  = '0;
    busy_vec  = '0;
    match_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < NumEntries; i++) begin
      free_vec[i]  = (state_q[i] == StFree);
      busy_vec[i]  = (state_q[i] != StFree);
      match_vec[i] = (state_q[i] == StWait) && (id_q[i] == bus_io.resp_in_id_i);
      done_vec[i]  = (state_q[i] == StDone);
    end
  end

  always_comb begin
    elig_vec = done_vec;
`ifdef SIMMEM_ID_ORDER_EN
    for (int i = 0; i < NumEntries; i++) begin
      for (int j = 0; j < NumEntries; j++) begin
        if (older_q[i][j] && busy_vec[j] && (id_q[j] == id_q[i])) elig_vec[i] = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    match_sel = '0;
    rel_sel   = '0;
    match_idx = '0;
    rel_idx   = '0;
    alloc_idx = '0;
    for (int i = 0; i < NumEntries; i++) begin
      match_sel[i] = match_vec[i] && !(|(match_vec & older_q[i]));
      rel_sel[i]   = elig_vec[i] && !(|(elig_vec & older_q[i]));
      if (match_sel[i]) match_idx = IdxWidth'(i);
      if (rel_sel[i])   rel_idx   = IdxWidth'(i);
    end
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IdxWidth'(i);
    end
  end

  assign bus_io.req_ready_o     = |free_vec;
  assign bus_io.resp_in_ready_o = |match_vec;
  assign alloc_en   = bus_io.req_valid_i && (|free_vec);
  assign match_en   = bus_io.resp_in_valid_i && (|match_vec);
  assign load_en    = !out_valid_q || bus_io.resp_out_ready_i;
  assign release_en = load_en && (|rel_sel);

  always_comb begin
    for (int i = 0; i < NumEntries; i++) begin
      state_d[i] = state_q[i];
      id_d[i]    = id_q[i];
      cnt_d[i]   = cnt_q[i];
      older_d[i] = older_q[i];
      if (state_q[i] == StDelay) begin
        cnt_d[i] = cnt_q[i] - CounterWidth'(1);
        if (cnt_q[i] == CounterWidth'(1)) state_d[i] = StDone;
      end
    end
    if (alloc_en) begin
      state_d[alloc_idx] = StWait;
      id_d[alloc_idx]    = bus_io.req_id_i;
      older_d[alloc_idx] = busy_vec;
      for (int j = 0; j < NumEntries; j++) older_d[j][alloc_idx] = 1'b0;
    end
    if (match_en) begin
      state_d[match_idx] = (bus_io.resp_in_delay_i == '0) ? StDone : StDelay;
      cnt_d[match_idx]   = bus_io.resp_in_delay_i;
    end
    if (release_en) state_d[rel_idx] = StFree;

    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    if (load_en) out_valid_d = release_en;
    if (release_en) begin
      out_id_d   = id_q[rel_idx];
      out_data_d = data_q[rel_idx];
    end
    occ_d = occ_q + OccWidth'(alloc_en) - OccWidth'(release_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i] <= StFree;
        id_q[i]    <= '0;
        cnt_q[i]   <= '0;
        older_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      occ_q       <= '0;
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        state_q[i] <= state_d[i];
        id_q[i]    <= id_d[i];
        cnt_q[i]   <= cnt_d[i];
        older_q[i] <= older_d[i];
      end
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      occ_q       <= occ_d;
    end
  end

  // Payload storage is qualified by entry state, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (match_en) data_q[match_idx] <= bus_io.resp_in_data_i;
  end

  assign bus_io.resp_out_valid_o = out_valid_q;
  assign bus_io.resp_out_id_o    = out_id_q;
  assign bus_io.resp_out_data_o  = out_data_q;
  assign bus_io.occupancy_o      = occ_q;
endmodule

// File: tb/tb_simmem_resp_bank.sv
// Directed self-checking bench for simmem_resp_bank.
module tb_simmem_resp_bank;
  logic clk_i;
  logic rst_ni;
  int unsigned checks;
  int unsigned passes;

  simmem_resp_bank_if #(
    .DataWidth(64), .IdWidth(8), .CounterWidth(8), .NumEntries(16)
  ) bus ();

  simmem_resp_bank #(
    .DataWidth(64), .IdWidth(8), .CounterWidth(8), .NumEntries(16)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus_io(bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i      = 1'b0;
    bus.req_id_i         = '0;
    bus.resp_in_valid_i  = 1'b0;
    bus.resp_in_id_i     = '0;
    bus.resp_in_data_i   = '0;
    bus.resp_in_delay_i  = '0;
    bus.resp_out_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic do_req(input logic [7:0] id);
    bus.req_valid_i = 1'b1;
    bus.req_id_i    = id;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic do_resp(input logic [7:0] id, input logic [63:0] data, input logic [7:0] dly);
    bus.resp_in_valid_i = 1'b1;
    bus.resp_in_id_i    = id;
    bus.resp_in_data_i  = data;
    bus.resp_in_delay_i = dly;
    tick();
    bus.resp_in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.req_ready_o !== 1'b1) $display("FAIL reset_req_ready got %0b want 1", bus.req_ready_o);
      else passes++;
      checks++;
      if (bus.resp_in_ready_o !== 1'b0)
        $display("FAIL reset_resp_in_ready got %0b want 0", bus.resp_in_ready_o);
      else passes++;
      checks++;
      if (bus.resp_out_valid_o !== 1'b0 || bus.resp_out_id_o !== 8'h0 || bus.resp_out_data_o !== 64'h0)
        $display("FAIL reset_out got v=%0b id=%h d=%h want 0/00/0",
                 bus.resp_out_valid_o, bus.resp_out_id_o, bus.resp_out_data_o);
      else passes++;
      checks++;
      if (bus.occupancy_o !== 5'd0) $display("FAIL reset_occ got %0d want 0", bus.occupancy_o);
      else passes++;
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    do_req(8'h05);
    checks++;
    if (bus.occupancy_o !== 5'd1) $display("FAIL single_occ_alloc got %0d want 1", bus.occupancy_o);
    else passes++;
    bus.resp_in_valid_i = 1'b1;
    bus.resp_in_id_i    = 8'h05;
    bus.resp_in_data_i  = 64'hA5A5;
    bus.resp_in_delay_i = 8'd0;
    #1;
    checks++;
    if (bus.resp_in_ready_o !== 1'b1) $display("FAIL single_in_ready got %0b want 1", bus.resp_in_ready_o);
    else passes++;
    tick();
    bus.resp_in_valid_i = 1'b0;
    checks++;
    if (bus.resp_out_valid_o !== 1'b0) $display("FAIL single_t1_valid got %0b want 0", bus.resp_out_valid_o);
    else passes++;
    tick();
    checks++;
    if (bus.resp_out_valid_o !== 1'b1 || bus.resp_out_id_o !== 8'h05 || bus.resp_out_data_o !== 64'hA5A5)
      $display("FAIL single_t2_out got v=%0b id=%h d=%h want 1/05/a5a5",
               bus.resp_out_valid_o, bus.resp_out_id_o, bus.resp_out_data_o);
    else passes++;
    checks++;
    if (bus.occupancy_o !== 5'd0) $display("FAIL single_occ_empty got %0d want 0", bus.occupancy_o);
    else passes++;
    tick();
    checks++;
    if (bus.resp_out_valid_o !== 1'b0) $display("FAIL single_drained got %0b want 0", bus.resp_out_valid_o);
    else passes++;
  endtask

  task automatic test_delay();
    logic [7:0] delays [4];
    int n;
    delays = '{8'd0, 8'd1, 8'd7, 8'd255};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_req(8'h10 + 8'(k));
      do_resp(8'h10 + 8'(k), 64'h1000 + 64'(k), delays[k]);
      n = 1;
      while (!bus.resp_out_valid_o && n < 300) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 2 + int'(delays[k]))
        $display("FAIL delay_latency d=%0d got %0d want %0d", delays[k], n, 2 + int'(delays[k]));
      else passes++;
      checks++;
      if (bus.resp_out_data_o !== 64'h1000 + 64'(k))
        $display("FAIL delay_data got %h want %h", bus.resp_out_data_o, 64'h1000 + 64'(k));
      else passes++;
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 16; k++) do_req(8'h20 + 8'(k));
    checks++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL full_ready got %0b want 0", bus.req_ready_o);
    else passes++;
    checks++;
    if (bus.occupancy_o !== 5'd16) $display("FAIL full_occ got %0d want 16", bus.occupancy_o);
    else passes++;
    do_resp(8'h20, 64'h2020, 8'd0);
    checks++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL full_release_edge got %0b want 0", bus.req_ready_o);
    else passes++;
    tick();
    checks++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL full_freed_ready got %0b want 1", bus.req_ready_o);
    else passes++;
    checks++;
    if (bus.occupancy_o !== 5'd15) $display("FAIL full_freed_occ got %0d want 15", bus.occupancy_o);
    else passes++;
  endtask

  task automatic test_ordering();
    logic [63:0] got [2];
    logic [63:0] want0, want1;
    int n;
`ifdef SIMMEM_ID_ORDER_EN
    want0 = 64'h111;
    want1 = 64'h222;
`else
    want0 = 64'h222;
    want1 = 64'h111;
`endif
    do_reset();
    do_req(8'h03);
    do_req(8'h03);
    do_resp(8'h03, 64'h111, 8'd20);
    do_resp(8'h03, 64'h222, 8'd0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.resp_out_valid_o && n < 100) begin
        tick();
        n++;
      end
      got[k] = bus.resp_out_data_o;
      tick();
    end
    checks++;
    if (got[0] !== want0) $display("FAIL order_first got %h want %h", got[0], want0);
    else passes++;
    checks++;
    if (got[1] !== want1) $display("FAIL order_second got %h want %h", got[1], want1);
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.resp_out_ready_i = 1'b0;
    do_req(8'h41);
    do_req(8'h42);
    do_req(8'h43);
    do_resp(8'h41, 64'hB1, 8'd0);
    do_resp(8'h42, 64'hB2, 8'd0);
    do_resp(8'h43, 64'hB3, 8'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.resp_out_valid_o !== 1'b1 || bus.resp_out_id_o !== 8'h41 || bus.resp_out_data_o !== 64'hB1)
        $display("FAIL bp_hold got v=%0b id=%h d=%h want 1/41/b1",
                 bus.resp_out_valid_o, bus.resp_out_id_o, bus.resp_out_data_o);
      else passes++;
      tick();
    end
    checks++;
    if (bus.occupancy_o !== 5'd2) $display("FAIL bp_occ got %0d want 2", bus.occupancy_o);
    else passes++;
    bus.resp_out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.resp_out_valid_o !== 1'b1 || bus.resp_out_id_o !== 8'h41 + 8'(k))
        $display("FAIL bp_release got v=%0b id=%h want 1/%h",
                 bus.resp_out_valid_o, bus.resp_out_id_o, 8'h41 + 8'(k));
      else passes++;
      tick();
    end
    checks++;
    if (bus.resp_out_valid_o !== 1'b0) $display("FAIL bp_empty got %0b want 0", bus.resp_out_valid_o);
    else passes++;
  endtask

  task automatic test_unmatched();
    do_reset();
    do_req(8'h11);
    bus.resp_in_valid_i = 1'b1;
    bus.resp_in_id_i    = 8'h7F;
    bus.resp_in_data_i  = 64'hDEAD;
    #1;
    checks++;
    if (bus.resp_in_ready_o !== 1'b0) $display("FAIL unmatched_ready got %0b want 0", bus.resp_in_ready_o);
    else passes++;
    tick();
    tick();
    tick();
    checks++;
    if (bus.occupancy_o !== 5'd1 || bus.resp_out_valid_o !== 1'b0)
      $display("FAIL unmatched_state got occ=%0d v=%0b want 1/0", bus.occupancy_o, bus.resp_out_valid_o);
    else passes++;
    bus.resp_in_id_i = 8'h11;
    #1;
    checks++;
    if (bus.resp_in_ready_o !== 1'b1) $display("FAIL unmatched_wait_alive got %0b want 1", bus.resp_in_ready_o);
    else passes++;
    bus.resp_in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.resp_out_ready_i = 1'b0;
    do_req(8'h50);
    do_req(8'h51);
    do_resp(8'h51, 64'hCAFE, 8'd0);
    do_resp(8'h50, 64'hBEEF, 8'd100);
    tick();
    tick();
    checks++;
    if (bus.resp_out_valid_o !== 1'b1 || bus.resp_out_id_o !== 8'h51)
      $display("FAIL rstmid_pre got v=%0b id=%h want 1/51", bus.resp_out_valid_o, bus.resp_out_id_o);
    else passes++;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.resp_out_valid_o !== 1'b0 || bus.resp_out_id_o !== 8'h0 || bus.resp_out_data_o !== 64'h0)
      $display("FAIL rstmid_out got v=%0b id=%h d=%h want 0/00/0",
               bus.resp_out_valid_o, bus.resp_out_id_o, bus.resp_out_data_o);
    else passes++;
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.occupancy_o !== 5'd0 || bus.resp_in_ready_o !== 1'b0)
      $display("FAIL rstmid_ctl got rdy=%0b occ=%0d inrdy=%0b want 1/0/0",
               bus.req_ready_o, bus.occupancy_o, bus.resp_in_ready_o);
    else passes++;
    do_reset();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_delay();
    test_full();
    test_ordering();
    test_backpressure();
    test_unmatched();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
